// File: rtl/jk_excitation_driver_if.sv
// Request/response bundle between a requester and jk_excitation_driver.
// The requester uses the master modport and the driver uses the slave modport.
interface jk_excitation_driver_if #(
    parameter int unsigned N = 4
);
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_mode;
    logic [N-1:0] req_state;
    logic         resp_valid;
    logic         resp_ok;
    logic [N-1:0] mismatch;
    logic [2:0]   tries;

    modport master (
        output req_valid, req_mode, req_state,
        input  req_ready, resp_valid, resp_ok, mismatch, tries
    );

    modport slave (
        input  req_valid, req_mode, req_state,
        output req_ready, resp_valid, resp_ok, mismatch, tries
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// Drives J/K/preset/clear of a negedge JK flip-flop bank toward a requested target,
// checks the Q feedback on the following posedge, retries, and reports the outcome.
module jk_excitation_driver #(
    parameter int unsigned N         = 4,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    jk_excitation_driver_if.slave bus,
    input  logic [N-1:0]          q_fb,
    output logic [N-1:0]          j,
    output logic [N-1:0]          k,
    output logic                  pr_n,
    output logic                  clr_n
);
    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_e;
    typedef enum logic [1:0] {
        MODE_LOAD   = 2'b00,
        MODE_PRESET = 2'b01,
        MODE_CLEAR  = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    state_e       state_q, state_d;
    mode_e        mode_q, mode_d, req_mode_e, drv_mode;
    logic [N-1:0] target_q, target_d, accept_target, drv_target;
    logic [3:0]   try_q, try_d;
    logic [N-1:0] j_d, k_d, ex_j, ex_k;
    logic         pr_n_d, clr_n_d, ex_pr_n, ex_clr_n;
    logic         resp_valid_q, resp_valid_d;
    logic         resp_ok_q, resp_ok_d;
    logic [N-1:0] mismatch_q, mismatch_d;
    logic [2:0]   tries_q, tries_d;

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_ok    = resp_ok_q;
    assign bus.mismatch   = mismatch_q;
    assign bus.tries      = tries_q;

    assign req_mode_e = mode_e'(bus.req_mode);

    always_comb begin
        accept_target = q_fb;
        unique case (req_mode_e)
            MODE_LOAD:   accept_target = bus.req_state;
            MODE_PRESET: accept_target = '1;
            MODE_CLEAR:  accept_target = '0;
            default:     accept_target = q_fb;
        endcase
    end

    // Excitation shared by the first drive (request fields) and retries (latched fields).
    assign drv_mode   = (state_q == IDLE) ? req_mode_e : mode_q;
    assign drv_target = (state_q == IDLE) ? accept_target : target_q;

    always_comb begin
        ex_j     = '0;
        ex_k     = '0;
        ex_pr_n  = 1'b1;
        ex_clr_n = 1'b1;
        unique case (drv_mode)
            MODE_LOAD: begin
                ex_j = ~q_fb & drv_target;
                ex_k = q_fb & ~drv_target;
            end
            MODE_PRESET: ex_pr_n  = 1'b0;
            MODE_CLEAR:  ex_clr_n = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        target_d     = target_q;
        try_d        = try_q;
        j_d          = '0;
        k_d          = '0;
        pr_n_d       = 1'b1;
        clr_n_d      = 1'b1;
        resp_valid_d = 1'b0;
        resp_ok_d    = resp_ok_q;
        mismatch_d   = mismatch_q;
        tries_d      = tries_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d  = DRIVE;
                    mode_d   = req_mode_e;
                    target_d = accept_target;
                    try_d    = 4'd1;
                    j_d      = ex_j;
                    k_d      = ex_k;
                    pr_n_d   = ex_pr_n;
                    clr_n_d  = ex_clr_n;
                end
            end
            DRIVE: begin
                if (q_fb == target_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_ok_d    = 1'b1;
                    mismatch_d   = '0;
                    tries_d      = try_q[2:0];
                end else if (try_q <= 4'(MAX_RETRY)) begin
                    try_d   = try_q + 4'd1;
                    j_d     = ex_j;
                    k_d     = ex_k;
                    pr_n_d  = ex_pr_n;
                    clr_n_d = ex_clr_n;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_ok_d    = 1'b0;
                    mismatch_d   = q_fb ^ target_q;
                    // An 8-try count does not fit the 3-bit port and reads back as 0.
                    tries_d      = try_q[2:0];
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= MODE_LOAD;
            target_q     <= '0;
            try_q        <= '0;
            j            <= '0;
            k            <= '0;
            pr_n         <= 1'b1;
            clr_n        <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_ok_q    <= 1'b0;
            mismatch_q   <= '0;
            tries_q      <= '0;
        end else begin
            mode_q       <= mode_d;
            target_q     <= target_d;
            try_q        <= try_d;
            j            <= j_d;
            k            <= k_d;
            pr_n         <= pr_n_d;
            clr_n        <= clr_n_d;
            resp_valid_q <= resp_valid_d;
            resp_ok_q    <= resp_ok_d;
            mismatch_q   <= mismatch_d;
            tries_q      <= tries_d;
        end
    end
endmodule
